// File: rtl/reg_file.sv
// reg_file: parameterised register file with WIDTH-bit entries, DEPTH entries,
// one synchronous write port and NREAD combinational read ports.
// Entry 0 is hardwired to zero when ZERO_REG=1, as the MIPS $zero register requires.
// Defining REGFILE_BYPASS_EN forwards write data combinationally to matching
// read ports in the same cycle. Without it, reads show the stored value until
// the clock edge.
module reg_file #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int NREAD    = 2,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   we,
    input  logic [AW-1:0]          waddr,
    input  logic [WIDTH-1:0]       wdata,
    input  logic [NREAD*AW-1:0]    raddr,
    output logic [NREAD*WIDTH-1:0] rdata
);

    // One extra bit lets DEPTH = 2**AW be compared without overflow.
    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic             wr_en;
    logic [AW-1:0]    rd_addr [NREAD];
    logic             rd_ok   [NREAD];

    // An address is usable when it is in range and is not the hardwired zero entry.
    function automatic logic addr_ok(input logic [AW-1:0] a);
        logic in_range;
        logic is_zero;
        in_range = ({1'b0, a} < DEPTH_W);
        is_zero  = (ZERO_REG != 0) && (a == '0);
        return in_range && !is_zero;
    endfunction

    // Qualify the write so that out-of-range writes and writes to $zero are dropped.
    always_comb begin
        wr_en = we && addr_ok(waddr);
    end

    // Storage update. Reset has priority and discards any write presented in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[waddr] <= wdata;
        end
    end

    // Unpack the per-port read addresses and decide which ones may return data.
    always_comb begin
        for (int unsigned p = 0; p < NREAD; p++) begin
            rd_addr[p] = raddr[p*AW +: AW];
            rd_ok[p]   = addr_ok(rd_addr[p]);
        end
    end

    // Combinational read ports. Invalid or zero-register addresses read 0.
    always_comb begin
        rdata = '0;
        for (int unsigned p = 0; p < NREAD; p++) begin
            if (rd_ok[p]) begin
`ifdef REGFILE_BYPASS_EN
                if (rst_n && wr_en && (rd_addr[p] == waddr)) begin
                    rdata[p*WIDTH +: WIDTH] = wdata;
                end else begin
                    rdata[p*WIDTH +: WIDTH] = mem[rd_addr[p]];
                end
`else
                rdata[p*WIDTH +: WIDTH] = mem[rd_addr[p]];
`endif
            end
        end
    end

endmodule

// File: tb/tb_reg_file.sv
// Directed testbench for reg_file. It exercises three instances:
// the default configuration, a 12-entry, 8-bit, 3-port configuration,
// and a configuration with ZERO_REG=0.
module tb_reg_file;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk;
    logic rst_n;

    // Instance a: default parameters (32x32, 2 read ports, zero register)
    logic        a_we;
    logic [4:0]  a_waddr;
    logic [31:0] a_wdata;
    logic [9:0]  a_raddr;
    logic [63:0] a_rdata;

    // Instance b: WIDTH=8, DEPTH=12, NREAD=3 (AW=4)
    logic        b_we;
    logic [3:0]  b_waddr;
    logic [7:0]  b_wdata;
    logic [11:0] b_raddr;
    logic [23:0] b_rdata;

    // Instance c: WIDTH=16, DEPTH=4, NREAD=1, ZERO_REG=0 (AW=2)
    logic        c_we;
    logic [1:0]  c_waddr;
    logic [15:0] c_wdata;
    logic [1:0]  c_raddr;
    logic [15:0] c_rdata;

    int checks;
    int failures;

    reg_file u_a (
        .clk(clk), .rst_n(rst_n), .we(a_we), .waddr(a_waddr),
        .wdata(a_wdata), .raddr(a_raddr), .rdata(a_rdata)
    );

    reg_file #(.WIDTH(8), .DEPTH(12), .NREAD(3), .ZERO_REG(1)) u_b (
        .clk(clk), .rst_n(rst_n), .we(b_we), .waddr(b_waddr),
        .wdata(b_wdata), .raddr(b_raddr), .rdata(b_rdata)
    );

    reg_file #(.WIDTH(16), .DEPTH(4), .NREAD(1), .ZERO_REG(0)) u_c (
        .clk(clk), .rst_n(rst_n), .we(c_we), .waddr(c_waddr),
        .wdata(c_wdata), .raddr(c_raddr), .rdata(c_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // exp0/exp1: values read just before the edge without bypass.
    // fwd0/fwd1: with bypass enabled, that port instead reads wdata.
    typedef struct {
        logic        rst_n;
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] exp0;
        logic [31:0] exp1;
        logic        fwd0;
        logic        fwd1;
    } vec_t;

    vec_t tbl [16];

    initial begin
        logic [31:0] e0;
        logic [31:0] e1;

        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        a_we = 1'b0; a_waddr = '0; a_wdata = '0; a_raddr = '0;
        b_we = 1'b0; b_waddr = '0; b_wdata = '0; b_raddr = '0;
        c_we = 1'b0; c_waddr = '0; c_wdata = '0; c_raddr = '0;

        //            rst we waddr wdata         ra0 ra1 exp0          exp1          f0 f1
        tbl[0]  = '{1'b1, 1'b0, 5'd0,  32'h0,        5'd0,  5'd5,  32'h0,        32'h0,        1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd5,  32'h0,        32'h0,        1'b1, 1'b1};
        tbl[2]  = '{1'b1, 1'b0, 5'd0,  32'h0,        5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 5'd5,  32'h11111111, 5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, 5'd0,  32'h0,        5'd5,  5'd5,  32'h0,        32'h0,        1'b0, 1'b0};
        tbl[5]  = '{1'b1, 1'b1, 5'd3,  32'hAABBCCDD, 5'd3,  5'd3,  32'h0,        32'h0,        1'b1, 1'b1};
        tbl[6]  = '{1'b1, 1'b0, 5'd3,  32'h12345678, 5'd3,  5'd3,  32'hAABBCCDD, 32'hAABBCCDD, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 1'b0, 5'd0,  32'h0,        5'd3,  5'd3,  32'hAABBCCDD, 32'hAABBCCDD, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 1'b1, 5'd0,  32'h87654321, 5'd0,  5'd0,  32'h0,        32'h0,        1'b0, 1'b0};
        tbl[9]  = '{1'b1, 1'b0, 5'd0,  32'h0,        5'd0,  5'd3,  32'h0,        32'hAABBCCDD, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 1'b1, 5'd7,  32'h11223344, 5'd7,  5'd3,  32'h0,        32'hAABBCCDD, 1'b1, 1'b0};
        tbl[11] = '{1'b1, 1'b0, 5'd0,  32'h0,        5'd7,  5'd5,  32'h11223344, 32'h0,        1'b0, 1'b0};
        tbl[12] = '{1'b1, 1'b1, 5'd31, 32'hFFFFFFFF, 5'd31, 5'd30, 32'h0,        32'h0,        1'b1, 1'b0};
        tbl[13] = '{1'b1, 1'b0, 5'd0,  32'h0,        5'd31, 5'd7,  32'hFFFFFFFF, 32'h11223344, 1'b0, 1'b0};
        tbl[14] = '{1'b1, 1'b1, 5'd30, 32'h00000001, 5'd29, 5'd7,  32'h0,        32'h11223344, 1'b0, 1'b0};
        tbl[15] = '{1'b1, 1'b0, 5'd0,  32'h0,        5'd30, 5'd3,  32'h00000001, 32'hAABBCCDD, 1'b0, 1'b0};

        // Initial reset, two edges
        @(negedge clk);
        @(negedge clk);

        // Inputs change at negedge. Outputs are sampled 4 ns later, before the next posedge.
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            rst_n   = tbl[i].rst_n;
            a_we    = tbl[i].we;
            a_waddr = tbl[i].waddr;
            a_wdata = tbl[i].wdata;
            a_raddr = {tbl[i].ra1, tbl[i].ra0};
            #4;
            e0 = (BYP && tbl[i].fwd0) ? tbl[i].wdata : tbl[i].exp0;
            e1 = (BYP && tbl[i].fwd1) ? tbl[i].wdata : tbl[i].exp1;
            check($sformatf("vec%0d_port0", i), a_rdata[31:0],  e0);
            check($sformatf("vec%0d_port1", i), a_rdata[63:32], e1);
        end
        @(negedge clk);
        a_we = 1'b0;

        // Instance b: write 0x5A to entry 11 while port 2 reads entry 11
        b_we = 1'b1; b_waddr = 4'd11; b_wdata = 8'h5A;
        b_raddr = {4'd11, 4'd12, 4'd13};
        #4;
        check("b_same_cycle_p2_addr11", {24'h0, b_rdata[23:16]}, BYP ? 32'h5A : 32'h0);
        check("b_addr12_oor_read",      {24'h0, b_rdata[15:8]},  32'h0);
        // Instance b: write 0xFF to out-of-range entry 13 while port 0 reads entry 13
        @(negedge clk);
        b_waddr = 4'd13; b_wdata = 8'hFF;
        #4;
        check("b_oor_write_bypass_p0", {24'h0, b_rdata[7:0]},   32'h0);
        check("b_p2_addr11_after",     {24'h0, b_rdata[23:16]}, 32'h5A);
        @(negedge clk);
        b_we = 1'b0;
        #4;
        check("b_addr13_reads_zero", {24'h0, b_rdata[7:0]}, 32'h0);
        // Sweep port 1 over every entry; only entry 11 holds data
        for (int a = 0; a < 16; a++) begin
            @(negedge clk);
            b_raddr = {4'd11, 4'(a), 4'd0};
            #4;
            check($sformatf("b_sweep_addr%0d", a), {24'h0, b_rdata[15:8]}, (a == 11) ? 32'h5A : 32'h0);
        end

        // Instance c: with ZERO_REG=0, entry 0 is ordinary storage
        @(negedge clk);
        c_we = 1'b1; c_waddr = 2'd0; c_wdata = 16'hBEEF; c_raddr = 2'd0;
        #4;
        check("c_addr0_same_cycle", {16'h0, c_rdata}, BYP ? 32'hBEEF : 32'h0);
        @(negedge clk);
        c_waddr = 2'd3; c_wdata = 16'h1234; c_raddr = 2'd0;
        #4;
        check("c_addr0_stored", {16'h0, c_rdata}, 32'hBEEF);
        @(negedge clk);
        c_we = 1'b0; c_raddr = 2'd3;
        #4;
        check("c_addr3_stored", {16'h0, c_rdata}, 32'h1234);
        @(negedge clk);
        c_raddr = 2'd1;
        #4;
        check("c_addr1_untouched", {16'h0, c_rdata}, 32'h0);

        // Reset clears every instance
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        b_raddr = {4'd11, 4'd11, 4'd11};
        c_raddr = 2'd0;
        #4;
        check("b_after_reset", {8'h0, b_rdata}, 32'h0);
        check("c_after_reset", {16'h0, c_rdata}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
